// File: rtl/bpf_mem_pkg.sv
// Shared packet-memory definitions for the BPF CPU cluster: transfer sizes
// and small elaboration-time helpers.
package bpf_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Ceiling log2, used to size pointer and requester-id fields.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic sz_is_legal(input logic [1:0] sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first asserted request at or
// above ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    // Scan from the farthest slot back toward ptr so the nearest requester is written last.
    for (int k = N - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(ptr_i) + k) % N);
      if (req_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_mem_arbiter.sv
// Round-robin arbiter sharing one packet-memory read port among N_CPU CPUs,
// with a tag pipeline that routes each response back to its issuer.
module packet_mem_arbiter
  import bpf_mem_pkg::*;
#(
  parameter int N_CPU   = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CPU-1:0]        req_rd_en,
  input  logic [N_CPU*ADDR_W-1:0] req_addr,
  input  logic [N_CPU*2-1:0]      req_transfer_sz,
  output logic [N_CPU-1:0]        req_stall,
  output logic [N_CPU-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [1:0]              mem_transfer_sz,
  input  logic [DATA_W-1:0]       mem_rd_data
);

  localparam int IDX_W = clog2(N_CPU);

  logic [N_CPU-1:0]  req_live;
  logic [N_CPU-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_sz;

  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [1:0]        mem_sz_q;
  logic [IDX_W-1:0]  launch_id_q;

  logic [MEM_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0][IDX_W-1:0] tag_id_q, tag_id_d;

  // No grants while in reset, but requesters still see their stall.
  assign req_live  = rst ? '0 : req_rd_en;
  assign req_stall = req_rd_en & ~gnt;

  rr_pick #(
    .N     (N_CPU),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i (req_live),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IDX_W'(N_CPU - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_sz   = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_sz   = req_transfer_sz[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_sz_q    <= SZ_BYTE;
      launch_id_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_rd_en_q <= gnt_any;
      if (gnt_any) begin
        mem_addr_q  <= sel_addr;
        mem_sz_q    <= sel_sz;
        launch_id_q <= gnt_idx;
      end
    end
  end

  // Stage 0 follows the launch register, so the last stage lines up with mem_rd_data.
  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_first
      assign tag_vld_d[gi] = mem_rd_en_q;
      assign tag_id_d[gi]  = launch_id_q;
    end else begin : g_next
      assign tag_vld_d[gi] = tag_vld_q[gi-1];
      assign tag_id_d[gi]  = tag_id_q[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  for (genvar gi = 0; gi < N_CPU; gi++) begin : g_rsp
    assign rsp_valid[gi] = tag_vld_q[MEM_LAT-1] && (tag_id_q[MEM_LAT-1] == IDX_W'(gi));
  end

  assign rsp_data        = mem_rd_data;
  assign mem_rd_en       = mem_rd_en_q;
  assign mem_addr        = mem_addr_q;
  assign mem_transfer_sz = mem_sz_q;

endmodule

// File: tb/tb_packet_mem_arbiter.sv
// Bench for packet_mem_arbiter: three instances (MEM_LAT 1..3) share stimulus and
// are compared against a cycle-history reference model of the arbitration rules.
module tb_packet_mem_arbiter;
  import bpf_mem_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int NI  = 3;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr_v;
  logic [N*2-1:0]  sz_v;

  logic [N-1:0]  stall_w [NI];
  logic [N-1:0]  rsp_w   [NI];
  logic [31:0]   rsp_data_w [NI];
  logic [31:0]   rdata_w [NI];
  logic          en_w    [NI];
  logic [AW-1:0] maddr_w [NI];
  logic [1:0]    msz_w   [NI];

  logic [31:0]   memdata [1024];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [31:0] dl [0:gi];

    packet_mem_arbiter #(.N_CPU(N), .ADDR_W(AW), .DATA_W(32), .MEM_LAT(gi + 1)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .req_rd_en       (req),
      .req_addr        (addr_v),
      .req_transfer_sz (sz_v),
      .req_stall       (stall_w[gi]),
      .rsp_valid       (rsp_w[gi]),
      .rsp_data        (rsp_data_w[gi]),
      .mem_rd_en       (en_w[gi]),
      .mem_addr        (maddr_w[gi]),
      .mem_transfer_sz (msz_w[gi]),
      .mem_rd_data     (rdata_w[gi])
    );

    // Memory model: data for the address presented appears gi+1 cycles later.
    always @(posedge clk) begin
      dl[0] <= memdata[maddr_w[gi]];
      for (int j = 1; j <= gi; j++) dl[j] <= dl[j-1];
    end
    assign rdata_w[gi] = dl[gi];
  end

  // Reference model state: per-cycle history of resets and grants.
  int          cyc = -1;
  int          ptr_m = 0;
  int          gnt_hist [HMAX];
  logic [AW-1:0] ga_hist [HMAX];
  logic [1:0]  gs_hist [HMAX];
  bit          rst_hist [HMAX];

  logic [N-1:0]  exp_stall;
  bit            exp_en;
  logic [AW-1:0] exp_addr;
  logic [1:0]    exp_sz;
  logic [N-1:0]  exp_rv [NI];
  logic [31:0]   exp_rd [NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step(input bit r, input logic [N-1:0] rq, input logic [N*AW-1:0] a,
                      input logic [N*2-1:0] s);
    int g;
    @(posedge clk);
    #1;
    cyc++;
    rst = r; req = rq; addr_v = a; sz_v = s;
    rst_hist[cyc] = r;
    g = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr_m + k) % N;
        if (rq[j] && g < 0) g = j;
      end
    end
    gnt_hist[cyc] = g;
    exp_stall = rq;
    if (g >= 0) begin
      exp_stall[g] = 1'b0;
      ga_hist[cyc] = a[g*AW +: AW];
      gs_hist[cyc] = s[g*2 +: 2];
      ptr_m = (g + 1) % N;
    end
    if (r) ptr_m = 0;
    exp_en = (cyc > 0) && (gnt_hist[cyc-1] >= 0);
    exp_addr = '0;
    exp_sz = '0;
    for (int k = cyc - 1; k >= 0; k--) begin
      if (rst_hist[k]) break;
      if (gnt_hist[k] >= 0) begin
        exp_addr = ga_hist[k];
        exp_sz   = gs_hist[k];
        break;
      end
    end
    for (int i = 0; i < NI; i++) begin
      int gg;
      bit ok;
      gg = cyc - 2 - i;
      exp_rv[i] = '0;
      exp_rd[i] = '0;
      if (gg >= 0 && gnt_hist[gg] >= 0) begin
        ok = 1'b1;
        for (int m = gg + 1; m <= cyc - 1; m++) if (rst_hist[m]) ok = 1'b0;
        if (ok) begin
          exp_rv[i][gnt_hist[gg]] = 1'b1;
          exp_rd[i] = memdata[ga_hist[gg]];
        end
      end
    end
    #1;
  endtask

  function automatic logic [N*AW-1:0] rand_addr();
    return (N*AW)'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 4'b1111, rand_addr(), 8'($urandom()));
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (stall_w[i] !== exp_stall) begin
          n_fail++;
          $display("FAIL reset_stall cyc=%0d lat=%0d got=%b exp=%b", cyc, i + 1, stall_w[i], exp_stall);
        end
        if (c == 1) begin
          n_checks++;
          if (en_w[i] !== exp_en || rsp_w[i] !== exp_rv[i] || maddr_w[i] !== exp_addr) begin
            n_fail++;
            $display("FAIL reset_regs cyc=%0d lat=%0d en=%b/%b rsp=%b/%b addr=%h/%h", cyc, i + 1,
                     en_w[i], exp_en, rsp_w[i], exp_rv[i], maddr_w[i], exp_addr);
          end
        end
      end
    end
    step(1'b0, 4'b1111, rand_addr(), 8'($urandom()));
    n_checks++;
    if (stall_w[0] !== exp_stall) begin
      n_fail++;
      $display("FAIL first_grant cyc=%0d got=%b exp=%b", cyc, stall_w[0], exp_stall);
    end
    step(1'b0, 4'b0000, rand_addr(), 8'($urandom()));
    n_checks++;
    if (en_w[0] !== exp_en || maddr_w[0] !== exp_addr) begin
      n_fail++;
      $display("FAIL first_launch cyc=%0d en=%b/%b addr=%h/%h", cyc, en_w[0], exp_en, maddr_w[0], exp_addr);
    end
  endtask

  task automatic test_single();
    logic [N*AW-1:0] a;
    logic [N*2-1:0]  s;
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0000, rand_addr(), 8'($urandom()));
    a = rand_addr();
    a[2*AW +: AW] = 10'h01C;
    s = 8'($urandom());
    s[5:4] = SZ_WORD;
    step(1'b0, 4'b0100, a, s);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 4'b0000, rand_addr(), 8'($urandom()));
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (en_w[i] !== exp_en || maddr_w[i] !== exp_addr || msz_w[i] !== exp_sz) begin
          n_fail++;
          $display("FAIL single_launch cyc=%0d lat=%0d en=%b/%b addr=%h/%h sz=%b/%b", cyc, i + 1,
                   en_w[i], exp_en, maddr_w[i], exp_addr, msz_w[i], exp_sz);
        end
        n_checks++;
        if (rsp_w[i] !== exp_rv[i] || (exp_rv[i] != 0 && rsp_data_w[i] !== exp_rd[i])) begin
          n_fail++;
          $display("FAIL single_rsp cyc=%0d lat=%0d rsp=%b/%b data=%h/%h", cyc, i + 1,
                   rsp_w[i], exp_rv[i], rsp_data_w[i], exp_rd[i]);
        end
      end
    end
  endtask

  task automatic test_contention();
    step(1'b0, 4'b1000, rand_addr(), 8'($urandom()));
    for (int c = 0; c < 14; c++) begin
      step(1'b0, (c < 8) ? 4'b1111 : 4'b0000, rand_addr(), 8'($urandom()));
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (stall_w[i] !== exp_stall || rsp_w[i] !== exp_rv[i] ||
            (exp_rv[i] != 0 && rsp_data_w[i] !== exp_rd[i])) begin
          n_fail++;
          $display("FAIL contention cyc=%0d lat=%0d stall=%b/%b rsp=%b/%b data=%h/%h", cyc, i + 1,
                   stall_w[i], exp_stall, rsp_w[i], exp_rv[i], rsp_data_w[i], exp_rd[i]);
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [N*AW-1:0] a;
    step(1'b0, 4'b0010, rand_addr(), 8'($urandom()));
    a = rand_addr();
    for (int c = 0; c < 3; c++) begin
      step(1'b0, (c == 0) ? 4'b1010 : (c == 1) ? 4'b0010 : 4'b0000, a, 8'hA5);
      n_checks++;
      if (stall_w[0] !== exp_stall || maddr_w[0] !== exp_addr || en_w[0] !== exp_en) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d stall=%b/%b en=%b/%b addr=%h/%h", cyc, stall_w[0], exp_stall,
                 en_w[0], exp_en, maddr_w[0], exp_addr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] seq [4] = '{4'b0001, 4'b0010, 4'b0010, 4'b0000};
    for (int c = 0; c < 10; c++) begin
      step(1'b0, (c < 4) ? seq[c] : 4'b0000, rand_addr(), 8'($urandom()));
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (en_w[i] !== exp_en || rsp_w[i] !== exp_rv[i] ||
            (exp_rv[i] != 0 && rsp_data_w[i] !== exp_rd[i])) begin
          n_fail++;
          $display("FAIL back_to_back cyc=%0d lat=%0d en=%b/%b rsp=%b/%b data=%h/%h", cyc, i + 1,
                   en_w[i], exp_en, rsp_w[i], exp_rv[i], rsp_data_w[i], exp_rd[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b0, 4'b0001, rand_addr(), 8'($urandom()));
    step(1'b1, 4'b0000, rand_addr(), 8'($urandom()));
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 4'b0000, rand_addr(), 8'($urandom()));
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (rsp_w[i] !== exp_rv[i] || en_w[i] !== exp_en) begin
          n_fail++;
          $display("FAIL reset_midflight cyc=%0d lat=%0d rsp=%b/%b en=%b/%b", cyc, i + 1,
                   rsp_w[i], exp_rv[i], en_w[i], exp_en);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0]    rq;
    logic [N*AW-1:0] a, na;
    logic [N*2-1:0]  s, ns;
    rq = '0; a = rand_addr(); s = 8'($urandom());
    for (int c = 0; c < 400; c++) begin
      na = rand_addr();
      ns = 8'($urandom());
      for (int k = 0; k < N; k++) begin
        // Stalled requesters usually hold; occasionally they withdraw.
        if (!(exp_stall[k] && $urandom_range(7) != 0)) begin
          rq[k] = ($urandom_range(1) == 1);
          a[k*AW +: AW] = na[k*AW +: AW];
          s[k*2 +: 2]   = ns[k*2 +: 2];
        end
      end
      step($urandom_range(63) == 0, rq, a, s);
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (stall_w[i] !== exp_stall || en_w[i] !== exp_en || maddr_w[i] !== exp_addr ||
            msz_w[i] !== exp_sz) begin
          n_fail++;
          $display("FAIL random_launch cyc=%0d lat=%0d stall=%b/%b en=%b/%b addr=%h/%h sz=%b/%b", cyc, i + 1,
                   stall_w[i], exp_stall, en_w[i], exp_en, maddr_w[i], exp_addr, msz_w[i], exp_sz);
        end
        n_checks++;
        if (rsp_w[i] !== exp_rv[i] || (exp_rv[i] != 0 && rsp_data_w[i] !== exp_rd[i])) begin
          n_fail++;
          $display("FAIL random_rsp cyc=%0d lat=%0d rsp=%b/%b data=%h/%h", cyc, i + 1,
                   rsp_w[i], exp_rv[i], rsp_data_w[i], exp_rd[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    addr_v = '0;
    sz_v = '0;
    for (int k = 0; k < 1024; k++) memdata[k] = $urandom();
    memdata[10'h01C] = 32'hDEADBEEF;
    test_reset();
    test_single();
    test_contention();
    test_stall_hold();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
